// File: rtl/scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// scan_decoder_pkg
//   Shared definitions for the scan_decoder block.
//   - mode_e      : internal mode register encoding (MODE_DIRECT / MODE_SCAN)
//   - num_outputs : number of one-hot outputs for a given select width
// ---------------------------------------------------------------------------
package scan_decoder_pkg;

   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   // N = 2^SEL_W
   function automatic int num_outputs(input int sel_w);
      return 1 << sel_w;
   endfunction

endpackage

// File: rtl/scan_decoder_dwell_counter.sv
// ---------------------------------------------------------------------------
// dwell_counter
//   Modulo-DWELL counter used to time how long each scan output stays active.
//   Counts 0..DWELL-1 while en=1, returning to 0 after the terminal count.
//   clr has priority over en and forces the count to 0.
//
//   Ports:
//     clk   in   system clock, rising edge
//     reset in   asynchronous active-high reset (count -> 0)
//     en    in   advance the count this cycle
//     clr   in   synchronous clear to 0
//     tc    out  terminal count: current count equals DWELL-1
// ---------------------------------------------------------------------------
module dwell_counter
   import scan_decoder_pkg::*;
#(
   parameter int unsigned DWELL = 4,
   localparam int unsigned CW   = $clog2(DWELL + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tc = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
//   Registered SEL_W-to-2^SEL_W one-hot decoder with enable and two modes:
//     direct : decodes a select value captured on load
//     scan   : steps through every output, holding each for DWELL cycles
//
//   Ports:
//     clk     in   system clock, rising edge
//     reset   in   asynchronous active-high reset
//     en      in   global enable; 0 blanks d and freezes index/count/mode
//     mode    in   0 = direct, 1 = scan
//     dir     in   (SCAN_REVERSE_EN only) 1 = scan descending
//     load    in   direct mode: capture sel this cycle
//     sel     in   direct-mode select value
//     d       out  registered one-hot outputs
//     cur_sel out  index currently driven in d
//     wrap    out  one-cycle pulse when the scan index wraps around
//
//   Build option: define SCAN_REVERSE_EN to add the dir port and
//   descending scan support.
// ---------------------------------------------------------------------------
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned DWELL = 4,
   localparam int unsigned N    = num_outputs(SEL_W)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
`ifdef SCAN_REVERSE_EN
   input  logic             dir,
`endif
   input  logic             load,
   input  logic [SEL_W-1:0] sel,
   output logic [N-1:0]     d,
   output logic [SEL_W-1:0] cur_sel,
   output logic             wrap
);

   mode_e            mode_q, mode_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [N-1:0]     d_q, d_d;
   logic             wrap_q, wrap_d;

   mode_e            mode_req;
   logic             mode_chg;
   logic             scan_run;
   logic             cnt_clr;
   logic             dwell_tc;
   logic             step_dn;

   assign mode_req = mode ? MODE_SCAN : MODE_DIRECT;

   // A mode change is only taken while enabled, and it owns the edge:
   // load and dwell advance are both suppressed on that cycle.
   assign mode_chg = en && (mode_req != mode_q);
   assign scan_run = en && (mode_q == MODE_SCAN) && !mode_chg;
   assign cnt_clr  = mode_chg && (mode_req == MODE_SCAN);

`ifdef SCAN_REVERSE_EN
   // Sampled only on the advance edge, so a mid-dwell change waits for it.
   assign step_dn = dir;
`else
   assign step_dn = 1'b0;
`endif

   dwell_counter #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk   (clk),
      .reset (reset),
      .en    (scan_run),
      .clr   (cnt_clr),
      .tc    (dwell_tc)
   );

   always_comb begin
      mode_d = mode_q;
      idx_d  = idx_q;
      wrap_d = 1'b0;
      d_d    = '0;

      if (en) begin
         if (mode_chg) begin
            mode_d = mode_req;
            // Entering scan restarts at index 0; leaving scan keeps the index.
            if (mode_req == MODE_SCAN) begin
               idx_d = '0;
            end
         end else if (mode_q == MODE_DIRECT) begin
            if (load) begin
               idx_d = sel;
            end
         end else if (dwell_tc) begin
            if (step_dn) begin
               idx_d  = idx_q - SEL_W'(1);
               wrap_d = (idx_q == '0);
            end else begin
               idx_d  = idx_q + SEL_W'(1);
               wrap_d = (idx_q == '1);
            end
         end
         d_d[idx_d] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q <= MODE_DIRECT;
         idx_q  <= '0;
         d_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         idx_q  <= idx_d;
         d_q    <= d_d;
         wrap_q <= wrap_d;
      end
   end

   assign d       = d_q;
   assign cur_sel = idx_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_scan_decoder
//   Self-checking bench for scan_decoder (SEL_W=3, DWELL=4).
//   The reference model tracks the scan position as "cycles since scan
//   entry" and derives index changes and wrap from that count.
// ---------------------------------------------------------------------------
module tb_scan_decoder;

   localparam int SEL_W = 3;
   localparam int DWELL = 4;
   localparam int N     = 8;

   logic             clk;
   logic             reset;
   logic             en;
   logic             mode;
   logic             dir_i;
   logic             load;
   logic [SEL_W-1:0] sel;
   logic [N-1:0]     d;
   logic [SEL_W-1:0] cur_sel;
   logic             wrap;

   int n_cmp;
   int n_err;

   scan_decoder #(
      .SEL_W (SEL_W),
      .DWELL (DWELL)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .mode    (mode),
`ifdef SCAN_REVERSE_EN
      .dir     (dir_i),
`endif
      .load    (load),
      .sel     (sel),
      .d       (d),
      .cur_sel (cur_sel),
      .wrap    (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit           m_mode;   // 0 direct, 1 scan
   int           m_idx;
   int           m_p;      // scan cycles elapsed since scan entry
   logic [N-1:0] m_d;
   bit           m_wrap;

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   function automatic int step(input int i, input bit dn);
      return dn ? (i + N - 1) % N : (i + 1) % N;
   endfunction

   function automatic bit wraps(input int i, input bit dn);
      return dn ? (i == 0) : (i == N - 1);
   endfunction

   function automatic bit adv(input int p);
      return ((p + 1) % DWELL) == 0;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode <= 1'b0;
         m_idx  <= 0;
         m_p    <= 0;
         m_d    <= '0;
         m_wrap <= 1'b0;
      end else if (!en) begin
         m_d    <= '0;
         m_wrap <= 1'b0;
      end else if (mode != m_mode) begin
         m_mode <= mode;
         m_wrap <= 1'b0;
         if (mode) begin
            m_idx <= 0;
            m_p   <= 0;
            m_d   <= onehot(0);
         end else begin
            m_d   <= onehot(m_idx);
         end
      end else if (!m_mode) begin
         m_idx  <= load ? int'(sel) : m_idx;
         m_d    <= onehot(load ? int'(sel) : m_idx);
         m_wrap <= 1'b0;
      end else begin
         m_p    <= m_p + 1;
         m_idx  <= adv(m_p) ? step(m_idx, dir_i) : m_idx;
         m_d    <= onehot(adv(m_p) ? step(m_idx, dir_i) : m_idx);
         m_wrap <= adv(m_p) && wraps(m_idx, dir_i);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      check("model_d",       32'(d),       32'(m_d));
      check("model_cur_sel", 32'(cur_sel), 32'(m_idx));
      check("model_wrap",    32'(wrap),    32'(m_wrap));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      en    = 1'b0;
      mode  = 1'b0;
      dir_i = 1'b0;
      load  = 1'b0;
      sel   = '0;
      #1;
      check("reset_d",       32'(d),       32'h0);
      check("reset_cur_sel", 32'(cur_sel), 32'h0);
      check("reset_wrap",    32'(wrap),    32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // direct load of 5
      @(negedge clk);
      en   = 1'b1;
      load = 1'b1;
      sel  = 3'd5;
      tick();
      check("load5_d",       32'(d),       32'h20);
      check("load5_cur_sel", 32'(cur_sel), 32'd5);
      check("load5_wrap",    32'(wrap),    32'h0);
      @(negedge clk);
      load = 1'b0;

      // scan entry at edge k=0; run to index 3, count 2 (k=78)
      @(negedge clk);
      mode = 1'b1;
      for (int k = 0; k < 79; k++) begin
         tick();
         if (k == 0) check("scan_entry_d", 32'(d), 32'h01);
         if (k == 5) check("scan_k5_d", 32'(d), 32'h02);
         if (k == 31) begin
            check("scan_k31_d",    32'(d),    32'h80);
            check("scan_k31_wrap", 32'(wrap), 32'h0);
         end
         if (k == 32 || k == 64) begin
            check("scan_wrap_d",    32'(d),    32'h01);
            check("scan_wrap_wrap", 32'(wrap), 32'h1);
         end
      end

      // enable drop while at index 3
      @(negedge clk);
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("en_off_d",       32'(d),       32'h0);
         check("en_off_cur_sel", 32'(cur_sel), 32'd3);
      end
      @(negedge clk);
      en = 1'b1;
      tick();
      check("resume_d",       32'(d),       32'h08);
      check("resume_cur_sel", 32'(cur_sel), 32'd3);
      tick();
      check("resume_adv_d",   32'(d),       32'h10);

      // advance to index 6, mid-dwell, then async reset
      repeat (9) tick();
      check("pre_reset_cur_sel", 32'(cur_sel), 32'd6);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_d",       32'(d),       32'h0);
      check("async_reset_cur_sel", 32'(cur_sel), 32'h0);
      @(negedge clk);
      mode = 1'b0;
      load = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("fresh_direct_d",       32'(d),       32'h01);
      check("fresh_direct_cur_sel", 32'(cur_sel), 32'h0);

      // mode change and load on the same edge
      @(negedge clk);
      load = 1'b1;
      sel  = 3'd2;
      tick();
      check("load2_d", 32'(d), 32'h04);
      @(negedge clk);
      mode = 1'b1;
      load = 1'b1;
      sel  = 3'd7;
      tick();
      check("same_edge_d",       32'(d),       32'h01);
      check("same_edge_cur_sel", 32'(cur_sel), 32'h0);
      check("same_edge_wrap",    32'(wrap),    32'h0);

      // randomized phase
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         en   = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 24) == 0) mode = ~mode;
         load = 1'($urandom_range(0, 1));
         sel  = SEL_W'($urandom);
`ifdef SCAN_REVERSE_EN
         if ($urandom_range(0, 7) == 0) dir_i = ~dir_i;
`endif
         if ($urandom_range(0, 499) == 0) begin
            #2;
            reset = 1'b1;
            #1;
            check("rand_async_reset_d", 32'(d), 32'h0);
            #1;
            reset = 1'b0;
         end
      end
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
